// File: rtl/serial_adder_core.sv
// serial_adder_core: bit-serial LSB-first adder feeding the display `num` word.
// Operands are captured on an accepted start, summed one bit per clock through
// a single full-adder cell and carry flop, and committed to the output holding
// register only on completion. All outputs are registered.
// Optional build macro: DISP_CLAMP_EN (saturate the committed sum to DISP_MAX
// when the addition carries out or exceeds the displayable range).
module serial_adder_core #(
    parameter int WIDTH    = 10,
    parameter int DISP_MAX = 999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Majority of three inputs: the carry produced by a full-adder cell.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Sum bit of a full-adder cell.
    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   sh_a_r, sh_a_nxt_s;
    logic [WIDTH-1:0]   sh_b_r, sh_b_nxt_s;
    logic [WIDTH-1:0]   sh_s_r, sh_s_nxt_s;
    logic               carry_r, carry_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic [WIDTH-1:0]   sum_r, sum_nxt_s;
    logic               overflow_r, overflow_nxt_s;

    logic               bit_s;
    logic               carry_out_s;
    logic [WIDTH-1:0]   raw_s;
    logic [WIDTH-1:0]   result_s;

    assign bit_s       = fa_sum(sh_a_r[0], sh_b_r[0], carry_r);
    assign carry_out_s = maj3(sh_a_r[0], sh_b_r[0], carry_r);
    // Partial-sum register after this cycle's bit is inserted at the MSB.
    assign raw_s       = {bit_s, sh_s_r[WIDTH-1:1]};

`ifdef DISP_CLAMP_EN
    localparam logic [WIDTH-1:0] DISP_MAX_V = WIDTH'(DISP_MAX);
    // Saturate to the display ceiling on carry-out or out-of-range result.
    assign result_s = (carry_out_s || (raw_s > DISP_MAX_V)) ? DISP_MAX_V : raw_s;
`else
    assign result_s = raw_s;
`endif

    // Next-state and datapath update: load in IDLE, one serial bit per SHIFT cycle.
    always_comb begin
        state_nxt_s    = state_r;
        sh_a_nxt_s     = sh_a_r;
        sh_b_nxt_s     = sh_b_r;
        sh_s_nxt_s     = sh_s_r;
        carry_nxt_s    = carry_r;
        cnt_nxt_s      = cnt_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        sum_nxt_s      = sum_r;
        overflow_nxt_s = overflow_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    sh_a_nxt_s  = a;
                    sh_b_nxt_s  = b;
                    sh_s_nxt_s  = {WIDTH{1'b0}};
                    carry_nxt_s = 1'b0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = SHIFT;
                end else begin
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                // start is deliberately ignored here: operands are already captured.
                sh_a_nxt_s  = {1'b0, sh_a_r[WIDTH-1:1]};
                sh_b_nxt_s  = {1'b0, sh_b_r[WIDTH-1:1]};
                sh_s_nxt_s  = raw_s;
                carry_nxt_s = carry_out_s;
                cnt_nxt_s   = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    sum_nxt_s      = result_s;
                    overflow_nxt_s = carry_out_s;
                    done_nxt_s     = 1'b1;
                    busy_nxt_s     = 1'b0;
                    state_nxt_s    = IDLE;
                end else begin
                    busy_nxt_s     = 1'b1;
                    state_nxt_s    = SHIFT;
                end
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset (aborts any addition).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sh_a_r     <= {WIDTH{1'b0}};
            sh_b_r     <= {WIDTH{1'b0}};
            sh_s_r     <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sum_r      <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sh_a_r     <= sh_a_nxt_s;
            sh_b_r     <= sh_b_nxt_s;
            sh_s_r     <= sh_s_nxt_s;
            carry_r    <= carry_nxt_s;
            cnt_r      <= cnt_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            sum_r      <= sum_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_serial_adder_core.sv
// tb_serial_adder_core: directed-vector bench with a scoreboard queue. The
// stimulus process pushes the expected result and completion cycle for every
// accepted start; a monitor pops and compares whenever done is presented.
module tb_serial_adder_core;

    localparam int W = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         overflow;

    typedef struct {
        logic [W-1:0] s;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   done_seen;

    serial_adder_core #(.WIDTH(W), .DISP_MAX(999)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to check completion latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected committed value, with saturation when the clamp build is used.
    function automatic logic [W-1:0] exp_sum(input int x, input int y);
        int r;
        r = x + y;
`ifdef DISP_CLAMP_EN
        if (r > 999) return 10'd999;
`endif
        return W'(r % 1024);
    endfunction

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_seen++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with sum %0d, expected no done (cycle %0d)", sum, cyc);
            end else begin
                e = q.pop_front();
                chk("sum", int'(sum), int'(e.s));
                chk("overflow", int'(overflow), int'(e.ov));
                chk("done_latency", cyc, e.cyc);
            end
        end
    end

    // Drive start for one cycle from the current negedge; optionally expect a result.
    task automatic issue(input int x, input int y, input bit push);
        exp_t e;
        a     = W'(x);
        b     = W'(y);
        start = 1'b1;
        if (push) begin
            e.s   = exp_sum(x, y);
            e.ov  = ((x + y) > 1023) ? 1'b1 : 1'b0;
            e.cyc = cyc + 11;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for the negedge at which done is high.
    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done, expected done within 30 cycles", name);
        end
    endtask

    task automatic add(input int x, input int y);
        @(negedge clk);
        issue(x, y, 1'b1);
        wait_done("add");
    endtask

    initial begin
        int seen0;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        done_seen = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = 10'd0;
        b         = 10'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sum", int'(sum), 0);
        chk("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;

        // 123+456: busy for exactly 10 sampled cycles, then one done.
        @(negedge clk);
        issue(123, 456, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("busy_high", int'(busy), 1);
            chk("no_early_done", int'(done), 0);
            @(negedge clk);
        end
        chk("done_pulse", int'(done), 1);
        chk("busy_low_at_done", int'(busy), 0);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        repeat (3) @(negedge clk);
        chk("sum_held", int'(sum), 579);

        add(500, 499);
        add(0, 0);
        add(1023, 1);
        add(600, 600);
        add(700, 300);
        add(512, 512);

        // Start during busy is ignored; restart in the done cycle is accepted.
        @(negedge clk);
        issue(100, 200, 1'b1);
        repeat (3) @(negedge clk);
        a     = 10'd7;
        b     = 10'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");
        issue(7, 8, 1'b1);
        wait_done("restart");

        // Reset mid-addition aborts without a done.
        @(negedge clk);
        issue(300, 300, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_sum", int'(sum), 0);
        chk("abort_overflow", int'(overflow), 0);
        seen0 = done_seen;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_seen, seen0);
        add(1, 2);

        // Operand changes after acceptance have no effect.
        @(negedge clk);
        issue(250, 250, 1'b1);
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom_range(1023, 0));
            b = W'($urandom_range(1023, 0));
            @(negedge clk);
            if (done) break;
        end
        if (!done) wait_done("operand_change");

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
